// File: rtl/operand_stack_if.sv
// Command/adder/status bundle between the stack CPU datapath (master) and the operand stack (slave).
interface operand_stack_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          op_valid;
  logic [2:0]    op;
  logic [31:0]   push_data;
  logic          op_ready;
  logic [31:0]   operand1;
  logic [31:0]   operand2;
  logic          neg1;
  logic          neg2;
  logic [31:0]   sum;
  logic [31:0]   tos;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [31:0]   pop_data;
  logic          pop_valid;
  logic          err_overflow;
  logic          err_underflow;

  modport master (
    output op_valid, op, push_data, sum,
    input  op_ready, operand1, operand2, neg1, neg2, tos, count,
           empty, full, pop_data, pop_valid, err_overflow, err_underflow
  );

  modport slave (
    input  op_valid, op, push_data, sum,
    output op_ready, operand1, operand2, neg1, neg2, tos, count,
           empty, full, pop_data, pop_valid, err_overflow, err_underflow
  );
endinterface

// File: rtl/operand_stack.sv
// Operand stack for the stack CPU: single-edge stack ops, two-edge ADD/SUB/NEG through the
// external adder, full/empty flags and sticky overflow/underflow errors.
module operand_stack #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  operand_stack_if.slave  stk
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_NEG  = 3'b101,
    OP_DUP  = 3'b110,
    OP_SWAP = 3'b111
  } op_e;

  typedef enum logic {
    IDLE,
    ALU
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] count_q;
  logic [AW-1:0] top_idx, nos_idx, alu_dst_q;
  logic          alu_dec_q;
  logic [31:0]   tos_w, nos_w;
  op_e           cmd;
  logic          op_ready;
  logic          accept, ovf, unf, ok, is_arith;
  logic [31:0]   operand1_q, operand2_q, pop_data_q;
  logic          neg1_q, neg2_q, pop_valid_q;
  logic          err_ovf_q, err_unf_q;

  always_comb begin
    top_idx = AW'(count_q - CW'(1));
    nos_idx = AW'(count_q - CW'(2));
    tos_w   = (count_q == '0) ? '0 : mem[top_idx];
    nos_w   = mem[nos_idx];
  end

  assign op_ready = (state_q == IDLE);

  // Depth checks are evaluated against the pre-command count; a failing command changes nothing but the error flag.
  always_comb begin
    cmd      = op_e'(stk.op);
    is_arith = cmd inside {OP_ADD, OP_SUB, OP_NEG};
    ovf      = (cmd inside {OP_PUSH, OP_DUP}) && (count_q == CW'(DEPTH));
    unf      = ((cmd inside {OP_POP, OP_NEG, OP_DUP}) && (count_q == '0)) ||
               ((cmd inside {OP_ADD, OP_SUB, OP_SWAP}) && (count_q < CW'(2)));
    accept   = stk.op_valid && op_ready;
    ok       = accept && !ovf && !unf;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ok && is_arith) state_d = ALU;
      ALU:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      operand1_q  <= '0;
      operand2_q  <= '0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      alu_dst_q   <= '0;
      alu_dec_q   <= 1'b0;
    end else begin
      pop_valid_q <= 1'b0;
      if (accept && ovf) err_ovf_q <= 1'b1;
      if (accept && unf) err_unf_q <= 1'b1;
      if (ok) begin
        case (cmd)
          OP_PUSH, OP_DUP: count_q <= count_q + CW'(1);
          OP_POP: begin
            count_q     <= count_q - CW'(1);
            pop_data_q  <= tos_w;
            pop_valid_q <= 1'b1;
          end
          OP_ADD, OP_SUB: begin
            operand1_q <= nos_w;
            operand2_q <= tos_w;
            neg1_q     <= 1'b0;
            neg2_q     <= (cmd == OP_SUB);
            alu_dst_q  <= nos_idx;
            alu_dec_q  <= 1'b1;
          end
          OP_NEG: begin
            operand1_q <= tos_w;
            operand2_q <= '0;
            neg1_q     <= 1'b1;
            neg2_q     <= 1'b0;
            alu_dst_q  <= top_idx;
            alu_dec_q  <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state_q == ALU && alu_dec_q) count_q <= count_q - CW'(1);
    end
  end

  // Storage carries no reset; a reset during ALU suppresses the write-back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ok) begin
        case (cmd)
          OP_PUSH: mem[AW'(count_q)] <= stk.push_data;
          OP_DUP:  mem[AW'(count_q)] <= tos_w;
          OP_SWAP: begin
            mem[top_idx] <= nos_w;
            mem[nos_idx] <= tos_w;
          end
          default: ;
        endcase
      end
      if (state_q == ALU) mem[alu_dst_q] <= stk.sum;
    end
  end

  assign stk.op_ready      = op_ready;
  assign stk.operand1      = operand1_q;
  assign stk.operand2      = operand2_q;
  assign stk.neg1          = neg1_q;
  assign stk.neg2          = neg2_q;
  assign stk.tos           = tos_w;
  assign stk.count         = count_q;
  assign stk.empty         = (count_q == '0);
  assign stk.full          = (count_q == CW'(DEPTH));
  assign stk.pop_data      = pop_data_q;
  assign stk.pop_valid     = pop_valid_q;
  assign stk.err_overflow  = err_ovf_q;
  assign stk.err_underflow = err_unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: fixed vector table, hand-written multi-cycle sequences and random
// commands checked against a queue-based model of the stack.
module tb_operand_stack;
  localparam int DEPTH = 16;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, NEG = 3'd5, DUP = 3'd6, SWAP = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  operand_stack_if #(.DEPTH(DEPTH)) bus ();

  operand_stack #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .stk   (bus)
  );

  always #5 clk = ~clk;

  // External 32-bit adder with negate inputs.
  assign bus.sum = (bus.neg1 ? (~bus.operand1 + 32'd1) : bus.operand1) +
                   (bus.neg2 ? (~bus.operand2 + 32'd1) : bus.operand2);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] mq[$];
  logic [31:0] m_pop_data, m_op1, m_op2;
  bit          m_pv, m_neg1, m_neg2, m_ovf, m_unf;

  typedef struct {
    bit          rst;
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] exp_tos;
    int unsigned exp_count;
    bit          exp_ovf;
    bit          exp_unf;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pop_data = '0; m_op1 = '0; m_op2 = '0;
    m_pv = 0; m_neg1 = 0; m_neg2 = 0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic logic [31:0] m_tos();
    return (mq.size() == 0) ? 32'd0 : mq[mq.size()-1];
  endfunction

  // Command-level semantics; arith reports whether the adder cycle follows.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] d, output bit arith);
    logic [31:0] a, b;
    arith = 0;
    m_pv = 0;
    case (op)
      PUSH: if (mq.size() == DEPTH) m_ovf = 1; else mq.push_back(d);
      POP: if (mq.size() == 0) m_unf = 1;
           else begin m_pop_data = mq.pop_back(); m_pv = 1; end
      ADD, SUB: if (mq.size() < 2) m_unf = 1;
           else begin
             a = mq.pop_back(); b = mq.pop_back();
             m_op1 = b; m_op2 = a; m_neg1 = 0; m_neg2 = (op == SUB);
             mq.push_back(op == SUB ? b - a : b + a);
             arith = 1;
           end
      NEG: if (mq.size() < 1) m_unf = 1;
           else begin
             a = mq.pop_back();
             m_op1 = a; m_op2 = 0; m_neg1 = 1; m_neg2 = 0;
             mq.push_back(32'd0 - a);
             arith = 1;
           end
      DUP: if (mq.size() == DEPTH) m_ovf = 1;
           else if (mq.size() == 0) m_unf = 1;
           else mq.push_back(m_tos());
      SWAP: if (mq.size() < 2) m_unf = 1;
           else begin a = mq.pop_back(); b = mq.pop_back(); mq.push_back(a); mq.push_back(b); end
      default: ;
    endcase
  endtask

  task automatic check_operands();
    check("operand1", bus.operand1, m_op1);
    check("operand2", bus.operand2, m_op2);
    check("neg1", 32'(bus.neg1), 32'(m_neg1));
    check("neg2", 32'(bus.neg2), 32'(m_neg2));
  endtask

  task automatic check_state();
    check("count", 32'(bus.count), 32'(mq.size()));
    check("tos", bus.tos, m_tos());
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check("err_overflow", 32'(bus.err_overflow), 32'(m_ovf));
    check("err_underflow", 32'(bus.err_underflow), 32'(m_unf));
    check("op_ready", 32'(bus.op_ready), 32'd1);
    check("pop_valid", 32'(bus.pop_valid), 32'(m_pv));
    check("pop_data", bus.pop_data, m_pop_data);
    check_operands();
  endtask

  task automatic do_reset();
    bus.op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check_state();
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    m_pv = 0;
    check_state();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] d);
    bit arith;
    int unsigned pre_count;
    pre_count = mq.size();
    bus.op_valid = 1'b1; bus.op = op; bus.push_data = d;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    model_apply(op, d, arith);
    if (arith) begin
      check("alu_op_ready", 32'(bus.op_ready), 32'd0);
      check("alu_count_held", 32'(bus.count), 32'(pre_count));
      check("alu_pop_valid", 32'(bus.pop_valid), 32'd0);
      check_operands();
      @(posedge clk); #1;
    end
    check_state();
  endtask

  task automatic add_vec(input bit rst, input logic [2:0] op, input logic [31:0] data,
                         input logic [31:0] et, input int unsigned ec, input bit eo, input bit eu);
    vec_t v;
    v.rst = rst; v.op = op; v.data = data;
    v.exp_tos = et; v.exp_count = ec; v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] rdata;

    add_vec(1, NOP,  0,            32'h0,        0, 0, 0);
    add_vec(0, PUSH, 32'd5,        32'd5,        1, 0, 0);
    add_vec(0, PUSH, 32'd3,        32'd3,        2, 0, 0);
    add_vec(0, SUB,  0,            32'd2,        1, 0, 0);
    add_vec(0, POP,  0,            32'd0,        0, 0, 0);
    add_vec(0, PUSH, 32'd7,        32'd7,        1, 0, 0);
    add_vec(0, NEG,  0,            32'hFFFFFFF9, 1, 0, 0);
    add_vec(0, ADD,  0,            32'hFFFFFFF9, 1, 0, 1);
    add_vec(0, NOP,  0,            32'hFFFFFFF9, 1, 0, 1);
    add_vec(1, NOP,  0,            32'h0,        0, 0, 0);
    add_vec(0, PUSH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
    add_vec(0, PUSH, 32'd1,        32'd1,        2, 0, 0);
    add_vec(0, ADD,  0,            32'd0,        1, 0, 0);
    add_vec(0, DUP,  0,            32'd0,        2, 0, 0);
    add_vec(0, SWAP, 0,            32'd0,        2, 0, 0);
    add_vec(0, PUSH, 32'h80000000, 32'h80000000, 3, 0, 0);
    add_vec(0, NEG,  0,            32'h80000000, 3, 0, 0);
    add_vec(0, SUB,  0,            32'h80000000, 2, 0, 0);
    add_vec(0, SWAP, 0,            32'd0,        2, 0, 0);
    add_vec(0, POP,  0,            32'h80000000, 1, 0, 0);
    add_vec(0, POP,  0,            32'd0,        0, 0, 0);
    add_vec(0, POP,  0,            32'd0,        0, 0, 1);

    bus.op_valid = 1'b0; bus.op = NOP; bus.push_data = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else issue(vecs[i].op, vecs[i].data);
      check($sformatf("vec%0d_tos", i), bus.tos, vecs[i].exp_tos);
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ovf", i), 32'(bus.err_overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 32'(bus.err_underflow), 32'(vecs[i].exp_unf));
    end

    // Fill to DEPTH, overflow, then POP off the top.
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(PUSH, 32'(i * 3 + 1));
    check("fill_full", 32'(bus.full), 32'd1);
    issue(PUSH, 32'hDEAD);
    check("ovf_flag", 32'(bus.err_overflow), 32'd1);
    check("ovf_tos", bus.tos, 32'(DEPTH * 3 - 2));
    issue(DUP, 0);
    issue(POP, 0);
    check("pop_pulse", 32'(bus.pop_valid), 32'd1);
    check("pop_word", bus.pop_data, 32'(DEPTH * 3 - 2));
    check("pop_not_full", 32'(bus.full), 32'd0);
    idle_cycle();
    check("pop_pulse_end", 32'(bus.pop_valid), 32'd0);

    // Command held valid across the ALU cycle is taken only once op_ready returns.
    do_reset();
    issue(PUSH, 32'd10);
    issue(PUSH, 32'd4);
    bus.op_valid = 1'b1; bus.op = ADD;
    @(posedge clk); #1;
    bus.op = PUSH; bus.push_data = 32'h55;
    check("hold_alu_ready", 32'(bus.op_ready), 32'd0);
    @(posedge clk); #1;
    check("hold_add_count", 32'(bus.count), 32'd1);
    check("hold_add_tos", bus.tos, 32'd14);
    check("hold_no_err", 32'(bus.err_overflow | bus.err_underflow), 32'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    check("hold_push_count", 32'(bus.count), 32'd2);
    check("hold_push_tos", bus.tos, 32'h55);
    mq.delete(); mq.push_back(32'd14); mq.push_back(32'h55);
    m_op1 = 32'd10; m_op2 = 32'd4; m_neg1 = 0; m_neg2 = 0; m_pv = 0;
    check_state();

    // Reset during the ALU cycle discards the result.
    do_reset();
    issue(PUSH, 32'd9);
    issue(PUSH, 32'd6);
    bus.op_valid = 1'b1; bus.op = ADD;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check_state();
    issue(PUSH, 32'd2);

    // Random commands against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 150; k++) begin
        rop = 3'($urandom_range(0, 7));
        if (r < 2 && $urandom_range(0, 2) == 0) rop = PUSH;
        case ($urandom_range(0, 5))
          0: rdata = 32'hFFFFFFFF;
          1: rdata = 32'h80000000;
          2: rdata = 32'd0;
          default: rdata = $urandom;
        endcase
        issue(rop, rdata);
        if ($urandom_range(0, 7) == 0) idle_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the single-cycle stack CPU datapath, sitting directly upstream and downstream of the 32-bit adder. Holds up to DEPTH 32-bit words and accepts one stack command per handshake. For ADD/SUB/NEG it registers operands and negate flags onto the adder inputs, then writes the adder's sum back as the new top of stack. Flags full/empty and records sticky overflow/underflow errors.

## Interface
- DEPTH, 16: number of 32-bit entries; power of two, ≥ 2.
- CW, log2(DEPTH)+1: width of `count`; derived, not overridden.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  command offered this cycle.
- op  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 NEG, 110 DUP, 111 SWAP.
- push_data  in  32  operand for PUSH.
- op_ready  out  1  block can accept a command this cycle.
- operand1  out  32  adder input 1 (registered).
- operand2  out  32  adder input 2 (registered).
- neg1  out  1  adder negate flag for operand1 (registered).
- neg2  out  1  adder negate flag for operand2 (registered).
- sum  in  32  adder result; combinational from operand1/2, neg1/2.
- tos  out  32  current top of stack; 0 when empty.
- count  out  CW  entries held, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- pop_data  out  32  word removed by last POP.
- pop_valid  out  1  one-cycle pulse with pop_data.
- err_overflow  out  1  sticky; cleared only by reset.
- err_underflow  out  1  sticky; cleared only by reset.

## Operation
- A command is accepted on a rising edge where op_valid && op_ready. NOS = entry below TOS.
- FSM states: IDLE, ALU.
  - IDLE: op_ready = 1. PUSH, POP, DUP, SWAP, NOP complete at the accept edge and stay in IDLE.
  - ADD/SUB/NEG with sufficient depth go to ALU at the accept edge. Operand registers load at the same edge.
  - ALU: op_ready = 0. At the end of this cycle, sum is written into the destination slot, count is updated, and the FSM returns to IDLE.
- Operand loading:
  - ADD: operand1 = NOS, operand2 = TOS, neg1 = 0, neg2 = 0.
  - SUB: operand1 = NOS, operand2 = TOS, neg1 = 0, neg2 = 1. Result is NOS − TOS.
  - NEG: operand1 = TOS, operand2 = 0, neg1 = 1, neg2 = 0. Result replaces TOS.
- ADD and SUB pop two entries and push the result, so count decreases by 1. NEG leaves count unchanged.
- Arithmetic is modulo 2^32; carry out is discarded and no overflow flag is produced. Example: NEG of 0x80000000 gives 0x80000000.
- Depth requirements (checked at accept):
  - PUSH, DUP need count < DEPTH; otherwise no state change and err_overflow ← 1.
  - POP, NEG, DUP need count ≥ 1; ADD, SUB, SWAP need count ≥ 2. Otherwise no state change, FSM stays in IDLE, err_underflow ← 1.
- POP: pop_data ← TOS, pop_valid pulses high for the cycle after the accept edge. A failed POP produces no pulse.
- SWAP exchanges TOS and NOS in one edge.
- Operand registers hold their values outside ALU; they change only when an arithmetic command is accepted.

## Timing
- Reset values: count 0, empty 1, full 0, tos 0, op_ready 1, operand1/2 0, neg1/2 0, pop_data 0, pop_valid 0, err_* 0, FSM in IDLE. Storage contents are don't-care.
- PUSH/POP/DUP/SWAP latency: 1 edge. tos, count, full and empty reflect the result in the cycle after accept. Back-to-back commands are accepted every cycle.
- ADD/SUB/NEG latency: 2 edges.
  - Accept at edge N; the cycle after edge N is ALU.
  - Result is visible on tos and count after edge N+1.
  - op_ready is low for exactly one cycle; the next command is accepted at edge N+2 at the earliest.
- op_valid while op_ready = 0 is ignored and causes no error. The upstream source must hold the command until accepted.
- reset asserted during ALU: the result is discarded and all outputs return to reset values at that edge.
- The adder path operand regs → adder → storage must close within one clock period.

## Test plan
- Reset, then PUSH 5, PUSH 3 on back-to-back cycles -> count=2, tos=3, empty=0.
- PUSH 5, PUSH 3, SUB -> operand1=5, operand2=3, neg2=1 during ALU, op_ready low one cycle; then tos=2, count=1.
- PUSH 0x00000007, NEG -> tos=0xFFFFFFF9, count=1; ADD with count=1 -> err_underflow=1, tos/count unchanged.
- Fill DEPTH entries, then PUSH 0xDEAD -> full=1, err_overflow=1, tos unchanged; POP -> pop_valid pulse with the old TOS, full=0.
- PUSH 0xFFFFFFFF, PUSH 1, ADD -> tos=0 (wrap); DUP then SWAP with count=2 -> both entries 0, no errors.
- Accept ADD, assert reset during the ALU cycle -> count=0, tos=0, op_ready=1, err_*=0 on the next cycle.
